// File: rtl/gen_rr_arbiter.sv
// gen_rr_arbiter: N-channel round-robin arbiter, registered one-hot grant, saturating per-channel grant counters.
// Define ARB_LOCK_EN to add a `lock` input that pins the current grant while high.
module gen_rr_arbiter #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  parameter bit HOLD  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         req,
  input  logic                   done,
`ifdef ARB_LOCK_EN
  input  logic                   lock,
`endif
  output logic [NCH-1:0]         grant,
  output logic                   grant_vld,
  output logic [$clog2(NCH)-1:0] grant_id,
  output logic [NCH*CNT_W-1:0]   cnt_bus
);

  localparam int IDW = $clog2(NCH);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [NCH-1:0] grant_q, grant_d;

  logic           lock_act;
  logic           release_c;
  logic           found_lo, found_hi;
  logic [IDW-1:0] sel_lo, sel_hi, sel_c;

`ifdef ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // Lowest requester at/after ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    found_lo = 1'b0;
    found_hi = 1'b0;
    sel_lo   = '0;
    sel_hi   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[k]) begin
        found_lo = 1'b1;
        sel_lo   = IDW'(k);
      end
      if (req[k] && (IDW'(k) >= ptr_q)) begin
        found_hi = 1'b1;
        sel_hi   = IDW'(k);
      end
    end
    sel_c = found_hi ? sel_hi : sel_lo;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    grant_d   = grant_q;
    release_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_lo) begin
          state_d = BUSY;
          id_d    = sel_c;
          grant_d = NCH'(1) << sel_c;
        end
      end
      BUSY: begin
        if (HOLD) release_c = (done || !req[id_q]) && !lock_act;
        else      release_c = !lock_act;
        if (release_c) begin
          state_d = IDLE;
          grant_d = '0;
          id_d    = '0;
          ptr_d   = (id_q == IDW'(NCH - 1)) ? '0 : id_q + IDW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      grant_q <= grant_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;

    // Counts grant rising edges, pinned at all-ones once full.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (grant_d[k] && !grant_q[k] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign cnt_bus[k*CNT_W +: CNT_W] = cnt_q;
  end

  assign grant     = grant_q;
  assign grant_vld = |grant_q;
  assign grant_id  = id_q;

endmodule
